// File: rtl/inp_debounce.sv
// Synchronises and debounces two 16-bit switch banks and a push-button.
// Outputs are stable values, per-bank change pulses, a button rising-edge pulse and a sticky valid flag.

module inp_debounce_chan #(
  parameter int unsigned W         = 16,
  parameter int unsigned DB_CYCLES = 400000,
  parameter int unsigned CNT_W     = 20
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] raw_i,
  output logic [W-1:0] out_o,
  output logic         chg_o,
  output logic         acc_o,
  output logic         sat_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic [W-1:0]     s1_q, s1_d;
  logic [W-1:0]     s2_q, s2_d;
  logic [W-1:0]     cand_q, cand_d;
  logic [W-1:0]     out_q, out_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             chg_q, chg_d;
  logic             acc_q, acc_d;
  logic             sat;

  // The whole word is one candidate: any bit moving restarts the stability count.
  always_comb begin
    s1_d   = raw_i;
    s2_d   = s1_q;
    cand_d = cand_q;
    cnt_d  = cnt_q;
    out_d  = out_q;
    acc_d  = acc_q;
    chg_d  = 1'b0;
    sat    = 1'b0;
    if (s2_q != cand_q) begin
      cand_d = s2_q;
      cnt_d  = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      sat   = 1'b1;
      acc_d = 1'b1;
      if (cand_q != out_q) begin
        out_d = cand_q;
        chg_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      cand_q <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
      chg_q  <= 1'b0;
      acc_q  <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      cand_q <= cand_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      chg_q  <= chg_d;
      acc_q  <= acc_d;
    end
  end

  assign out_o = out_q;
  assign chg_o = chg_q;
  assign acc_o = acc_q;
  assign sat_o = sat;

endmodule

module inp_debounce #(
  parameter int unsigned DB_CYCLES = 32'd400000,
  parameter int unsigned CNT_W     = 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] raw1,
  input  logic [15:0] raw2,
  input  logic        raw_btn,
  output logic [15:0] inpval1,
  output logic [15:0] inpval2,
  output logic        inp_valid,
  output logic [1:0]  inp_changed,
  output logic        btn_level,
  output logic        btn_pulse
);

  logic b1_chg, b1_acc, b1_sat;
  logic b2_chg, b2_acc, b2_sat;
  logic bt_chg, bt_acc, bt_sat;
  logic valid_q, valid_d;

  inp_debounce_chan #(.W(16), .DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_bank1 (
    .clock (clock),
    .reset (reset),
    .raw_i (raw1),
    .out_o (inpval1),
    .chg_o (b1_chg),
    .acc_o (b1_acc),
    .sat_o (b1_sat)
  );

  inp_debounce_chan #(.W(16), .DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_bank2 (
    .clock (clock),
    .reset (reset),
    .raw_i (raw2),
    .out_o (inpval2),
    .chg_o (b2_chg),
    .acc_o (b2_acc),
    .sat_o (b2_sat)
  );

  inp_debounce_chan #(.W(1), .DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)) u_btn (
    .clock (clock),
    .reset (reset),
    .raw_i (raw_btn),
    .out_o (btn_level),
    .chg_o (bt_chg),
    .acc_o (bt_acc),
    .sat_o (bt_sat)
  );

  // Include this edge's acceptances so valid rises on the edge the last channel is accepted.
  assign valid_d = valid_q | ((b1_acc | b1_sat) & (b2_acc | b2_sat) & (bt_acc | bt_sat));

  always_ff @(posedge clock) begin
    if (reset) valid_q <= 1'b0;
    else       valid_q <= valid_d;
  end

  assign inp_valid   = valid_q;
  assign inp_changed = {b2_chg, b1_chg};
  // A one-bit channel that just changed and now reads high has risen.
  assign btn_pulse   = bt_chg & btn_level;

endmodule
